// File: rtl/panel_vga_renderer.sv
// Connect-Four board renderer for a 640x480@60 VGA screen.
// The board inputs are latched once per frame at the start of vertical blanking,
// then drawn through a two-tick pixel pipeline with sync delayed to match.
module panel_vga_renderer #(
    parameter int CELL_LOG2    = 6,
    parameter int BOARD_X0     = 96,
    parameter int BOARD_Y0     = 96,
    parameter int DISC_R2      = 784,
    parameter int BLINK_FRAMES = 15,
    parameter int H_VIS        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VIS        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [41:0] color_p0,
    input  logic [41:0] color_p1,
    input  logic [41:0] winner_tokens,
    input  logic [2:0]  selected_col,
    input  logic        player,
    input  logic        invalid_move,
    input  logic        win_a,
    input  logic        win_b,
    input  logic        full_panel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_tick
);
    localparam int CELL = 1 << CELL_LOG2;
    localparam int DW   = CELL_LOG2 + 1;
    localparam int SW   = 2 * DW + 1;

    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] BX_BEG  = 10'(BOARD_X0);
    localparam logic [9:0] BX_END  = 10'(BOARD_X0 + 7 * CELL);
    localparam logic [9:0] BY_BEG  = 10'(BOARD_Y0);
    localparam logic [9:0] BY_END  = 10'(BOARD_Y0 + 6 * CELL);
    localparam logic [9:0] SY_BEG  = 10'(BOARD_Y0 - CELL);

    localparam logic signed [DW-1:0] HALF   = DW'(CELL / 2);
    localparam logic [SW-1:0]        R2     = SW'(DISC_R2);
    localparam logic [7:0]           BLK_LAST = 8'(BLINK_FRAMES - 1);

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;
    localparam logic [11:0] C_WHITE  = 12'hFFF;
    localparam logic [11:0] C_MAGENTA = 12'hF0F;

    logic        pix_en_r;
    logic [9:0]  hcnt_r, vcnt_r;
    logic        snap_s;

    logic [41:0] sh_p0_r, sh_p1_r, sh_win_r;
    logic [2:0]  sh_sel_r;
    logic        sh_player_r, sh_invalid_r, sh_nocur_r;
    logic [7:0]  frame_cnt_r;
    logic        blink_r;

    logic [9:0]  hoff_s, voff_s;
    logic [2:0]  col_s, srow_s, trow_s;
    logic [5:0]  idx_s;
    logic        in_bx_s, in_by_s, in_sy_s, vis_s, hsync_s, vsync_s;
    logic        p0_s, p1_s, win_s, cur_s;

    logic                 s1_vis_r, s1_board_r, s1_p0_r, s1_p1_r, s1_win_r, s1_cur_r;
    logic                 s1_hsync_r, s1_vsync_r;
    logic [CELL_LOG2-1:0] s1_dx_r, s1_dy_r;

    logic signed [DW-1:0]   dxd_s, dyd_s;
    logic signed [2*DW-1:0] dxe_s, dye_s;
    logic [2*DW-1:0]        dxq_s, dyq_s;
    logic [SW-1:0]          dist_s;
    logic                   disc_s;
    logic [11:0]            rgb_s;

    assign snap_s = pix_en_r && (hcnt_r == 10'd0) && (vcnt_r == V_VIS_C);

    // Pixel-enable divider and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en_r <= 1'b0;
            hcnt_r   <= 10'd0;
            vcnt_r   <= 10'd0;
        end else begin
            pix_en_r <= ~pix_en_r;
            if (pix_en_r) begin
                if (hcnt_r == H_LAST) begin
                    hcnt_r <= 10'd0;
                    vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
                end else begin
                    hcnt_r <= hcnt_r + 10'd1;
                end
            end
        end
    end

    // Once-per-frame input snapshot so a frame is drawn from one consistent board.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_p0_r      <= 42'd0;
            sh_p1_r      <= 42'd0;
            sh_win_r     <= 42'd0;
            sh_sel_r     <= 3'd0;
            sh_player_r  <= 1'b0;
            sh_invalid_r <= 1'b0;
            sh_nocur_r   <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= snap_s;
            if (snap_s) begin
                sh_p0_r      <= color_p0;
                sh_p1_r      <= color_p1;
                sh_win_r     <= winner_tokens;
                sh_sel_r     <= selected_col;
                sh_player_r  <= player;
                sh_invalid_r <= invalid_move;
                sh_nocur_r   <= win_a | win_b | full_panel;
            end
        end
    end

    // Blink timebase: counts snapshots while a winning line exists, idles at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 8'd0;
            blink_r     <= 1'b0;
        end else if (snap_s) begin
            if (|winner_tokens) begin
                if (frame_cnt_r == BLK_LAST) begin
                    frame_cnt_r <= 8'd0;
                    blink_r     <= ~blink_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end else begin
                frame_cnt_r <= 8'd0;
                blink_r     <= 1'b0;
            end
        end
    end

    // Stage-1 decode: cell coordinates, in-cell offsets, region flags and token lookups.
    always_comb begin
        hoff_s  = hcnt_r - BX_BEG;
        voff_s  = vcnt_r - BY_BEG;
        col_s   = 3'(hoff_s >> CELL_LOG2);
        srow_s  = 3'(voff_s >> CELL_LOG2);
        trow_s  = 3'd5 - srow_s;
        idx_s   = ({3'd0, trow_s} * 6'd7) + {3'd0, col_s};
        in_bx_s = (hcnt_r >= BX_BEG) && (hcnt_r < BX_END);
        in_by_s = (vcnt_r >= BY_BEG) && (vcnt_r < BY_END);
        in_sy_s = (vcnt_r >= SY_BEG) && (vcnt_r < BY_BEG);
        vis_s   = (hcnt_r < H_VIS_C) && (vcnt_r < V_VIS_C);
        hsync_s = (hcnt_r >= HS_BEG) && (hcnt_r < HS_END);
        vsync_s = (vcnt_r >= VS_BEG) && (vcnt_r < VS_END);
        p0_s    = 1'b0;
        p1_s    = 1'b0;
        win_s   = 1'b0;
        cur_s   = 1'b0;
        if (in_bx_s && in_by_s) begin
            p0_s  = sh_p0_r[idx_s];
            p1_s  = sh_p1_r[idx_s];
            win_s = sh_win_r[idx_s];
        end else begin
            p0_s  = 1'b0;
            p1_s  = 1'b0;
            win_s = 1'b0;
        end
        if (in_bx_s && in_sy_s && !sh_nocur_r && (sh_sel_r != 3'd7) && (sh_sel_r == col_s)) begin
            cur_s = 1'b1;
        end else begin
            cur_s = 1'b0;
        end
    end

    // Stage-1 registers, sync flags travel alongside the pixel data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vis_r   <= 1'b0;
            s1_board_r <= 1'b0;
            s1_p0_r    <= 1'b0;
            s1_p1_r    <= 1'b0;
            s1_win_r   <= 1'b0;
            s1_cur_r   <= 1'b0;
            s1_hsync_r <= 1'b0;
            s1_vsync_r <= 1'b0;
            s1_dx_r    <= {CELL_LOG2{1'b0}};
            s1_dy_r    <= {CELL_LOG2{1'b0}};
        end else if (pix_en_r) begin
            s1_vis_r   <= vis_s;
            s1_board_r <= in_bx_s && in_by_s;
            s1_p0_r    <= p0_s;
            s1_p1_r    <= p1_s;
            s1_win_r   <= win_s;
            s1_cur_r   <= cur_s;
            s1_hsync_r <= hsync_s;
            s1_vsync_r <= vsync_s;
            s1_dx_r    <= hoff_s[CELL_LOG2-1:0];
            s1_dy_r    <= voff_s[CELL_LOG2-1:0];
        end
    end

    // Stage-2 disc test (squared distance from cell centre) and colour selection.
    always_comb begin
        dxd_s  = $signed({1'b0, s1_dx_r}) - HALF;
        dyd_s  = $signed({1'b0, s1_dy_r}) - HALF;
        dxe_s  = (2*DW)'(dxd_s);
        dye_s  = (2*DW)'(dyd_s);
        dxq_s  = dxe_s * dxe_s;
        dyq_s  = dye_s * dye_s;
        dist_s = {1'b0, dxq_s} + {1'b0, dyq_s};
        disc_s = (dist_s < R2);
        rgb_s  = C_BLACK;
        if (!s1_vis_r) begin
            rgb_s = C_BLACK;
        end else if (s1_board_r) begin
            if (!disc_s) begin
                rgb_s = C_BLUE;
            end else if (s1_win_r && blink_r && (s1_p0_r || s1_p1_r)) begin
                rgb_s = C_WHITE;
            end else if (s1_p0_r) begin
                rgb_s = C_RED;
            end else if (s1_p1_r) begin
                rgb_s = C_YELLOW;
            end else begin
                rgb_s = C_BLACK;
            end
        end else if (s1_cur_r && disc_s) begin
            if (sh_invalid_r) begin
                rgb_s = C_MAGENTA;
            end else if (sh_player_r) begin
                rgb_s = C_YELLOW;
            end else begin
                rgb_s = C_RED;
            end
        end else begin
            rgb_s = C_BLACK;
        end
    end

    // Output registers; sync is active low on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (pix_en_r) begin
            vga_r  <= rgb_s[11:8];
            vga_g  <= rgb_s[7:4];
            vga_b  <= rgb_s[3:0];
            vga_hs <= ~s1_hsync_r;
            vga_vs <= ~s1_vsync_r;
        end
    end

endmodule
